// File: rtl/sys_defs.sv
// Shared definitions for the fetch-side branch target predictor: data width,
// BTB entry layout and 2-bit counter encodings.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int XLEN = `XLEN;

    // Widest tag any legal depth can need (NUM_ENTRIES=2); narrower tags are
    // zero-extended into this field so one struct serves every depth.
    localparam int TAG_MAX = XLEN - 3;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [XLEN-1:0]    target;
        logic               is_jump;
        ctr_t               ctr;
    } btb_entry_t;

    // Direction an entry would predict, ignoring whether it actually hits.
    function automatic logic entry_predicts_taken(input btb_entry_t e);
        return e.is_jump || e.ctr[1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import sys_defs::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        // NOTE: ctr_o gets a value before the case so no path can infer a latch.
        ctr_o = ctr_i;
        unique case (ctr_i)
            CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB: combinational direction/target lookup for the fetch PC,
// registered training from resolved branches and jumps.
module branch_target_predictor
    import sys_defs::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [`XLEN-1:0]  if_pc,
    output logic              pred_taken,
    output logic [`XLEN-1:0]  pred_target,
    output logic              pred_hit,
    input  logic              upd_valid,
    input  logic [`XLEN-1:0]  upd_pc,
    input  logic              upd_taken,
    input  logic [`XLEN-1:0]  upd_target,
    input  logic              upd_is_jump,
    output logic              upd_mispredict
);

    localparam int IDX_BITS = $clog2(NUM_ENTRIES);

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_MAX-1:0]  tag_t;

    function automatic idx_t idx_of(input logic [XLEN-1:0] pc);
        return idx_t'(pc >> 2);
    endfunction

    function automatic tag_t tag_of(input logic [XLEN-1:0] pc);
        return tag_t'(pc >> (IDX_BITS + 2));
    endfunction

    logic [NUM_ENTRIES-1:0] valid_q;
    tag_t                   tag_q    [NUM_ENTRIES];
    logic [XLEN-1:0]        target_q [NUM_ENTRIES];
    logic                   jump_q   [NUM_ENTRIES];
    ctr_t                   ctr_q    [NUM_ENTRIES];
    logic                   mis_q;
    logic                   mis_d;

    function automatic btb_entry_t read_entry(input idx_t idx);
        btb_entry_t e;
        e.valid   = valid_q[idx];
        e.tag     = tag_q[idx];
        e.target  = target_q[idx];
        e.is_jump = jump_q[idx];
        e.ctr     = ctr_q[idx];
        return e;
    endfunction

    // Fetch lookup sees only registered contents, so a same-cycle update is
    // not bypassed.
    idx_t       lk_idx;
    btb_entry_t lk_entry;

    always_comb begin
        lk_idx      = idx_of(if_pc);
        lk_entry    = read_entry(lk_idx);
        pred_hit    = lk_entry.valid && (lk_entry.tag == tag_of(if_pc));
        pred_taken  = pred_hit && entry_predicts_taken(lk_entry);
        pred_target = pred_taken ? lk_entry.target : if_pc + XLEN'(4);
    end

    idx_t            up_idx;
    btb_entry_t      up_entry;
    logic            up_hit;
    ctr_t            ctr_next;
    logic            stored_taken;
    logic [XLEN-1:0] stored_target;
    logic            wr_en;
    btb_entry_t      wr_entry;

    sat_counter2 u_ctr (
        .ctr_i   (up_entry.ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_next)
    );

    always_comb begin
        up_idx        = idx_of(upd_pc);
        up_entry      = read_entry(up_idx);
        up_hit        = up_entry.valid && (up_entry.tag == tag_of(upd_pc));
        stored_taken  = up_hit && entry_predicts_taken(up_entry);
        stored_target = stored_taken ? up_entry.target : upd_pc + XLEN'(4);
        mis_d         = upd_valid &&
                        ((stored_taken != upd_taken) ||
                         (upd_taken && (stored_target != upd_target)));

        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (upd_valid && up_hit) begin
            wr_en            = 1'b1;
            wr_entry.ctr     = ctr_next;
            wr_entry.is_jump = upd_is_jump;
            if (upd_taken) begin
                wr_entry.target = upd_target;
            end
        end else if (upd_valid && upd_taken) begin
            // Allocation evicts whatever occupies this index.
            wr_en            = 1'b1;
            wr_entry.valid   = 1'b1;
            wr_entry.tag     = tag_of(upd_pc);
            wr_entry.target  = upd_target;
            wr_entry.is_jump = upd_is_jump;
            wr_entry.ctr     = upd_is_jump ? CTR_ST : CTR_WT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                valid_q[up_idx] <= wr_entry.valid;
            end
            mis_q <= mis_d;
        end
    end

    // NOTE: the payload arrays are deliberately not reset; a cleared valid bit
    // makes their contents unobservable, and dropping reset keeps them plain flops.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[up_idx]    <= wr_entry.tag;
            target_q[up_idx] <= wr_entry.target;
            jump_q[up_idx]   <= wr_entry.is_jump;
            ctr_q[up_idx]    <= wr_entry.ctr;
        end
    end

    assign upd_mispredict = mis_q;

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch resolution logic: predicts direction and target for the fetch PC, then trains on resolved outcomes (taken/not-taken, target_pc) returned from execute.
- Direct-mapped BTB, one entry per index: valid, tag, target, is_jump, 2-bit saturating counter.
- Lookup is combinational on the current table contents; training is registered (one write per cycle).

Parameters:
- NUM_ENTRIES, 16, BTB depth; power of two, minimum 2.
- IDX_BITS, $clog2(NUM_ENTRIES), index width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_pc  in  `XLEN  fetch PC to predict.
- pred_taken  out  1  1 means redirect fetch to pred_target.
- pred_target  out  `XLEN  next fetch PC: BTB target if pred_taken, else if_pc+4.
- pred_hit  out  1  valid entry with matching tag exists for if_pc.
- upd_valid  in  1  a resolved control-flow instruction is presented this cycle.
- upd_pc  in  `XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved condition; always 1 for jumps.
- upd_target  in  `XLEN  resolved target_pc.
- upd_is_jump  in  1  0 means B-type, 1 means JAL/JALR.
- upd_mispredict  out  1  registered; 1 for one cycle after an update whose stored prediction differed from the outcome.

Behaviour:
- Index is pc[IDX_BITS+1:2]. Tag is pc[`XLEN-1:IDX_BITS+2]. pc[1:0] is ignored.
- Reset (async, reset_n=0): all valid bits cleared, upd_mispredict=0.
  - During reset, outputs follow the lookup rule below, so pred_hit=0, pred_taken=0 and pred_target=if_pc+4.
- Lookup (combinational): hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = hit && (is_jump[idx] || ctr[idx][1]).
  - pred_target = pred_taken ? target[idx] : if_pc+4. The add wraps modulo 2^`XLEN.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. It saturates at 00 and 11.
- Update, applied on a clock edge when upd_valid=1:
  - Hit at upd_pc:
    - ctr increments if upd_taken, else decrements (saturating).
    - target overwritten with upd_target only if upd_taken.
    - is_jump overwritten with upd_is_jump.
  - Miss and upd_taken=1: allocate the entry, overwriting any occupant.
    - valid=1, tag written, target=upd_target, is_jump=upd_is_jump.
    - ctr=11 for a jump, 10 for a branch.
  - Miss and upd_taken=0: no table change.
- upd_mispredict, registered on the same edge, uses the pre-update entry:
  - stored_taken = (pre-update hit) && (is_jump || ctr[1]).
  - stored_target = stored_taken ? target : upd_pc+4.
  - upd_mispredict = (stored_taken != upd_taken) || (upd_taken && stored_target != upd_target).
  - It is 0 in any cycle following upd_valid=0.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents; no bypass. The new contents are visible from the next cycle.
- Reset asserted mid-operation: an update in flight is discarded and the table is empty when reset_n rises.
- Table storage is flops, with no reset on tag, target or ctr; only valid and upd_mispredict are reset.

Decomposition:
- Shared package (sys_defs): `XLEN, a BTB entry struct (valid, tag, target, is_jump, ctr[1:0]), and counter-state constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
- One natural sub-module, sat_counter2: pure next-state function (ctr, taken) -> ctr', instantiated in the update path.

Test Plan:
- Reset then if_pc=0x0000_0100 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0104; assert reset_n=0 mid-test after training -> all lookups miss immediately.
- Update pc=0x100, taken=1, target=0x180, is_jump=0 -> upd_mispredict=1 next cycle; then if_pc=0x100 gives hit=1, taken=1, target=0x180 (ctr=10).
- Same branch: not-taken once -> ctr=01, pred_taken=0, upd_mispredict=1; taken x3 -> ctr=11; then not-taken -> ctr=10, still predicted taken.
- Jump pc=0x200, target=0x3F0, is_jump=1 -> ctr=11, always predicted taken. Re-update with target 0x400 -> upd_mispredict=1 (target mismatch), new target 0x400.
- Aliasing with NUM_ENTRIES=16: train pc=0x100, then taken at pc=0x140 (same index 0, different tag) -> 0x140 entry replaces it; if_pc=0x100 now misses. Not-taken at 0x180 -> no allocation.
- Same cycle, if_pc=upd_pc=0x100 with first-time training -> pred_hit=0 that cycle, pred_hit=1 the following cycle.
